// File: rtl/wired_tlb_match_array_pkg.sv
// rtl/wired_tlb_match_array_pkg.sv - shared key type, INVTLB op and walker state enums
package wired_tlb_match_array_pkg;

  localparam int VPPN_W = 19;
  localparam int ASID_W = 10;

  typedef struct packed {
    logic              e;
    logic              g;
    logic              huge_page;
    logic [ASID_W-1:0] asid;
    logic [VPPN_W-1:0] vppn;
  } tlb_key_t;

  typedef enum logic [4:0] {
    INV_ALL0        = 5'd0,
    INV_ALL1        = 5'd1,
    INV_G1          = 5'd2,
    INV_G0          = 5'd3,
    INV_G0_ASID     = 5'd4,
    INV_G0_ASID_VA  = 5'd5,
    INV_G1ORASID_VA = 5'd6
  } inv_op_e;

  typedef enum logic [1:0] {
    INV_IDLE = 2'd0,
    INV_WALK = 2'd1,
    INV_DONE = 2'd2
  } inv_state_e;

  function automatic logic inv_op_legal(input logic [4:0] op);
    return op <= INV_G1ORASID_VA;
  endfunction

endpackage

// File: rtl/wired_tlb_entry_cmp.sv
// rtl/wired_tlb_entry_cmp.sv - per-entry lookup match and INVTLB op match
module wired_tlb_entry_cmp
  import wired_tlb_match_array_pkg::*;
(
  input  tlb_key_t          key_i,
  input  logic [VPPN_W-1:0] vppn_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic [4:0]        op_i,
  output logic              lk_match_o,
  output logic              inv_match_o
);

  logic va_match;
  logic asid_match;

  // A huge page spans both halves of the pair, so the low VPPN bits are ignored.
  assign va_match   = (key_i.vppn[18:10] == vppn_i[18:10]) &&
                      (key_i.huge_page || (key_i.vppn[9:0] == vppn_i[9:0]));
  assign asid_match = (key_i.asid == asid_i);
  assign lk_match_o = key_i.e && va_match && (key_i.g || asid_match);

  always_comb begin
    inv_match_o = 1'b0;
    case (inv_op_e'(op_i))
      INV_ALL0, INV_ALL1: inv_match_o = 1'b1;
      INV_G1:             inv_match_o = key_i.g;
      INV_G0:             inv_match_o = !key_i.g;
      INV_G0_ASID:        inv_match_o = !key_i.g && asid_match;
      INV_G0_ASID_VA:     inv_match_o = !key_i.g && asid_match && va_match;
      INV_G1ORASID_VA:    inv_match_o = (key_i.g || asid_match) && va_match;
      default:            inv_match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wired_tlb_match_array.sv
// rtl/wired_tlb_match_array.sv - fully-associative TLB tag array with INVTLB walker
// Optional multi-hit detection: WIRED_TLB_MULTIHIT_CHK_EN.
module wired_tlb_match_array
  import wired_tlb_match_array_pkg::*;
#(
  parameter int ENTRIES      = 16,
  parameter int LOOKUP_PORTS = 2,
  parameter int IDX_W        = $clog2(ENTRIES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [LOOKUP_PORTS-1:0]         lk_valid_i,
  input  logic [LOOKUP_PORTS*VPPN_W-1:0]  lk_vppn_i,
  input  logic [LOOKUP_PORTS*ASID_W-1:0]  lk_asid_i,
  output logic [LOOKUP_PORTS-1:0]         lk_hit_o,
  output logic [LOOKUP_PORTS*IDX_W-1:0]   lk_idx_o,
  output logic [LOOKUP_PORTS-1:0]         lk_multi_o,
  input  logic                            wr_i,
  input  logic [IDX_W-1:0]                wr_idx_i,
  input  tlb_key_t                        wr_key_i,
  input  logic                            inv_valid_i,
  output logic                            inv_ready_o,
  input  logic [4:0]                      inv_op_i,
  input  logic [ASID_W-1:0]               inv_asid_i,
  input  logic [VPPN_W-1:0]               inv_vppn_i,
  output logic                            inv_done_o,
  output logic                            inv_err_o,
  output logic [IDX_W-1:0]                repl_idx_o
);

  logic [ENTRIES-1:0] e_q, e_d;
  logic [ENTRIES-1:0] g_q, huge_q;
  logic [ASID_W-1:0]  asid_q [ENTRIES];
  logic [VPPN_W-1:0]  vppn_q [ENTRIES];
  tlb_key_t           key    [ENTRIES];

  inv_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               err_q, err_d;
  logic [4:0]         inv_op_q, inv_op_d;
  logic [ASID_W-1:0]  inv_asid_q, inv_asid_d;
  logic [VPPN_W-1:0]  inv_vppn_q, inv_vppn_d;
  logic [IDX_W-1:0]   rr_q;

  logic [ENTRIES-1:0] lk_match      [LOOKUP_PORTS];
  logic [ENTRIES-1:0] lk_inv_unused [LOOKUP_PORTS];
  logic               wk_match;
  logic               wk_lk_unused;

  logic [LOOKUP_PORTS-1:0]       hit_d, hit_q;
  logic [LOOKUP_PORTS*IDX_W-1:0] idx_d, idx_q;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      key[i] = '{e: e_q[i], g: g_q[i], huge_page: huge_q[i], asid: asid_q[i], vppn: vppn_q[i]};
    end
  end

  for (genvar p = 0; p < LOOKUP_PORTS; p++) begin : g_port
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      wired_tlb_entry_cmp u_cmp (
        .key_i       (key[i]),
        .vppn_i      (lk_vppn_i[p*VPPN_W +: VPPN_W]),
        .asid_i      (lk_asid_i[p*ASID_W +: ASID_W]),
        .op_i        (inv_op_q),
        .lk_match_o  (lk_match[p][i]),
        .inv_match_o (lk_inv_unused[p][i])
      );
    end
  end

  wired_tlb_entry_cmp u_walk_cmp (
    .key_i       (key[ptr_q]),
    .vppn_i      (inv_vppn_q),
    .asid_i      (inv_asid_q),
    .op_i        (inv_op_q),
    .lk_match_o  (wk_lk_unused),
    .inv_match_o (wk_match)
  );

  // Write is applied after the walker clear so a same-index write wins.
  always_comb begin
    e_d = e_q;
    if (state_q == INV_WALK && wk_match) e_d[ptr_q] = 1'b0;
    if (wr_i) e_d[wr_idx_i] = wr_key_i.e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  always_ff @(posedge clk) begin
    if (wr_i) begin
      g_q[wr_idx_i]    <= wr_key_i.g;
      huge_q[wr_idx_i] <= wr_key_i.huge_page;
      asid_q[wr_idx_i] <= wr_key_i.asid;
      vppn_q[wr_idx_i] <= wr_key_i.vppn;
    end
  end

  always_comb begin
    hit_d = '0;
    idx_d = '0;
    for (int p = 0; p < LOOKUP_PORTS; p++) begin
      hit_d[p] = lk_valid_i[p] && (|lk_match[p]);
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (lk_match[p][i]) idx_d[p*IDX_W +: IDX_W] = IDX_W'(i);
      end
      if (!hit_d[p]) idx_d[p*IDX_W +: IDX_W] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
      idx_q <= '0;
    end else begin
      hit_q <= hit_d;
      idx_q <= idx_d;
    end
  end

  assign lk_hit_o = hit_q;
  assign lk_idx_o = idx_q;

`ifdef WIRED_TLB_MULTIHIT_CHK_EN
  logic [LOOKUP_PORTS-1:0] multi_d, multi_q;

  always_comb begin
    multi_d = '0;
    for (int p = 0; p < LOOKUP_PORTS; p++) begin
      multi_d[p] = lk_valid_i[p] && ($countones(lk_match[p]) > 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_q <= '0;
    else        multi_q <= multi_d;
  end

  assign lk_multi_o = multi_q;
`else
  assign lk_multi_o = '0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    inv_op_d    = inv_op_q;
    inv_asid_d  = inv_asid_q;
    inv_vppn_d  = inv_vppn_q;
    inv_ready_o = 1'b0;
    inv_done_o  = 1'b0;
    inv_err_o   = 1'b0;
    case (state_q)
      INV_IDLE: begin
        inv_ready_o = 1'b1;
        if (inv_valid_i) begin
          inv_op_d   = inv_op_i;
          inv_asid_d = inv_asid_i;
          inv_vppn_d = inv_vppn_i;
          ptr_d      = '0;
          err_d      = !inv_op_legal(inv_op_i);
          state_d    = inv_op_legal(inv_op_i) ? INV_WALK : INV_DONE;
        end
      end
      INV_WALK: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = INV_DONE;
      end
      INV_DONE: begin
        inv_done_o = 1'b1;
        inv_err_o  = err_q;
        state_d    = INV_IDLE;
      end
      default: state_d = INV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INV_IDLE;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vppn_q <= inv_vppn_d;
    end
  end

  // Round-robin victim only advances when software actually refills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rr_q <= '0;
    else if (wr_i && wr_idx_i == rr_q)  rr_q <= rr_q + IDX_W'(1);
  end

  always_comb begin
    repl_idx_o = rr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!e_q[i]) repl_idx_o = IDX_W'(i);
    end
  end

endmodule
